input_debounce: RTL
===================

INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples required to accept a new input level (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES), stability counter width.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 RAW_IN  input  1  asynchronous raw switch/button level.
REQ-006 LEVEL  output  1  debounced level, registered; drives the I input of the downstream state machine.
REQ-007 RISE  output  1  registered single-cycle pulse when LEVEL goes 0->1.
REQ-008 FALL  output  1  registered single-cycle pulse when LEVEL goes 1->0.

Function
REQ-009 RAW_IN SHALL pass through a two-flop synchronizer; the second flop output (SYNC) is the only value the FSM examines.
REQ-010 The FSM SHALL have four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-011 STABLE_LO: SYNC=1 -> PEND_HI with counter cleared to 0; otherwise remain.
REQ-012 PEND_HI: SYNC=0 -> STABLE_LO (glitch rejected, no output change); SYNC=1 with counter = DEBOUNCE_CYCLES-1 -> STABLE_HI, LEVEL<=1, RISE<=1; otherwise counter increments.
REQ-013 STABLE_HI: SYNC=0 -> PEND_LO with counter cleared to 0; otherwise remain.
REQ-014 PEND_LO: SYNC=1 -> STABLE_HI (glitch rejected); SYNC=0 with counter = DEBOUNCE_CYCLES-1 -> STABLE_LO, LEVEL<=0, FALL<=1; otherwise counter increments.
REQ-015 Latency: a RAW_IN change held stable SHALL appear on LEVEL exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it.
REQ-016 A SYNC excursion lasting <= DEBOUNCE_CYCLES cycles SHALL NOT change LEVEL or produce any pulse; one lasting >= DEBOUNCE_CYCLES+1 cycles SHALL be accepted.
REQ-017 The counter SHALL never wrap; it is cleared on every STABLE->PEND entry and only counts in PEND states.
REQ-018 RISE and FALL SHALL each be high for exactly one cycle per accepted transition, never simultaneously, and only in the cycle LEVEL changes.
REQ-019 Any unused state encoding SHALL recover to STABLE_LO on the next edge with LEVEL=0 and no pulse.

Reset
REQ-020 While RST=1 at a rising edge: synchronizer flops 0, state STABLE_LO, counter 0, LEVEL=0, RISE=0, FALL=0.
REQ-021 RST asserted mid-PEND SHALL abandon the pending transition with no pulse emitted.
REQ-022 RAW_IN held high through reset release SHALL be treated as a new press: RISE after DEBOUNCE_CYCLES+3 edges.

Structure
REQ-023 State encodings (2-bit) SHALL reside in the team's shared package/include file for reuse by other input-conditioning stages.
REQ-024 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff, with the same CLK/RST.
REQ-025 The FSM, counter and output registers SHALL be in input_debounce; no combinational path from RAW_IN to any output.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, RAW_IN=0 for 20 cycles -> LEVEL=0, RISE=FALL=0 throughout.
REQ-027 RAW_IN 0->1 held -> LEVEL=1 and RISE=1 for one cycle exactly 7 edges after first sampling edge; FALL stays 0.
REQ-028 RAW_IN high pulses of 1, 3 and 4 cycles separated by 10 low cycles -> LEVEL stays 0, no pulses; 5-cycle pulse -> RISE once, then FALL once 7 edges after the fall.
REQ-029 From STABLE_HI, RAW_IN low-bounces 1,0,1,0 each one cycle then low held -> exactly one FALL, LEVEL=0 7 edges after final low sampled.
REQ-030 RST pulsed during PEND_HI (counter=2) -> no RISE, LEVEL=0; RAW_IN still high -> RISE 7 edges after reset release.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared definitions for the input-conditioning stages.
//
// Contents:
//   deb_state_t  - 2-bit state encoding of the debounce FSM
//   is_pending() - true for the two states in which the stability counter runs
package input_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_t;

    function automatic logic is_pending(input deb_state_t s);
        return (s == PEND_HI) || (s == PEND_LO);
    endfunction

endpackage

// File: rtl/input_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//
// Ports:
//   CLK  in   system clock, rising edge
//   RST  in   synchronous active-high reset, clears both flops
//   D    in   asynchronous input level
//   Q    out  synchronized level (second flop)
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/input_debounce.sv
// Switch/button debouncer.
//
// RAW_IN is synchronized by sync_2ff; the FSM only looks at the synchronized
// value. A new level is accepted once it has been seen on DEBOUNCE_CYCLES+1
// consecutive edges (entry into PEND plus DEBOUNCE_CYCLES counted edges).
// All outputs are registered, so nothing combinational reaches them from RAW_IN.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   RAW_IN     in   asynchronous raw switch level
//   LEVEL      out  debounced level (registered)
//   RISE       out  one-cycle pulse in the cycle LEVEL goes 0->1
//   FALL       out  one-cycle pulse in the cycle LEVEL goes 1->0
//   DBG_STATE  out  current FSM state, for observation only
//
// Handshake: none; RAW_IN is a free-running level, outputs are plain
// registered levels/pulses with no valid/ready protocol.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RAW_IN,
    output logic       LEVEL,
    output logic       RISE,
    output logic       FALL,
    output logic [1:0] DBG_STATE
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync;
    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next, rise_next, fall_next;

    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (RAW_IN),
        .Q   (sync)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            LEVEL <= 1'b0;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            LEVEL <= level_next;
            RISE  <= rise_next;
            FALL  <= fall_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = LEVEL;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            STABLE_LO: begin
                level_next = 1'b0;
                if (sync) begin
                    state_next = PEND_HI;
                    cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (!sync) begin
                    state_next = STABLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_HI;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                level_next = 1'b1;
                if (!sync) begin
                    state_next = PEND_LO;
                    cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (sync) begin
                    state_next = STABLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_LO;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                // Unreachable encodings fall back to a quiet low state.
                state_next = STABLE_LO;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
        // Counter only moves while a transition is pending; it is held otherwise.
        if (!is_pending(state) && !is_pending(state_next)) begin
            cnt_next = cnt;
        end
    end

    assign DBG_STATE = state;

endmodule
